// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and sizing helpers for the framebuffer arbiter.
// Imported by the arbiter top and its bench.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        VGA_BURST,
        VGA_CPU_SLOT
    } fb_arb_state_t;

    localparam int DEF_BURST_LEN   = 80;
    localparam int DEF_SLOT_PERIOD = 8;

    // Beat counter indexes 0..BURST_LEN-1; keep at least one bit.
    function automatic int beat_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

    // Slot counter must be able to hold the period value itself.
    function automatic int slot_width(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU data-bus port of the framebuffer arbiter.
// master = bus decoder side, slave = arbiter side.
interface vga_fb_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                    cpu_req;
    logic                    cpu_we;
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [DATA_WIDTH/8-1:0] cpu_wstrb;
    logic                    cpu_ack;
    logic [DATA_WIDTH-1:0]   cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr,
        output cpu_wdata, cpu_wstrb,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr,
        input  cpu_wdata, cpu_wstrb,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA line bursts have priority,
// the CPU gets one guaranteed slot every CPU_SLOT_PERIOD beats.
module vga_fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int CPU_SLOT_PERIOD = DEF_SLOT_PERIOD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vga_req,
    input  logic [ADDR_WIDTH-1:0]   vga_base_addr,
    output logic                    vga_rvalid,
    output logic [DATA_WIDTH-1:0]   vga_rdata,
    output logic                    vga_done,
    output logic                    vga_busy,
    output logic                    vga_overrun,
    vga_fb_arbiter_if.slave         cpu,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BW = beat_width(BURST_LEN);
    localparam int SW = slot_width(CPU_SLOT_PERIOD);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(CPU_SLOT_PERIOD);

    fb_arb_state_t         state, state_n;
    logic [ADDR_WIDTH-1:0] base_q, base_n, base_cur, iss_addr;
    logic [BW-1:0]         beat_q, beat_n, beat_cur;
    logic [SW-1:0]         slot_q, slot_n, slot_cur;
    logic                  vga_iss, cpu_iss, last_n;
    logic                  vga_rd_q, last_q, cpu_rd_q;
    logic                  vga_start, cpu_pend, cpu_wr;

    // A request that is being acked this cycle is not served again.
    assign vga_start = vga_req && !vga_busy;
    assign cpu_pend  = cpu.cpu_req && !cpu.cpu_ack;
    assign cpu_wr    = cpu_iss && cpu.cpu_we;

    // Read data is shared; the valid/ack strobes qualify it.
    assign vga_rdata     = mem_rdata;
    assign cpu.cpu_rdata = mem_rdata;

    // Next-state, counter update and issue selection.
    always_comb begin
        state_n  = state;
        base_n   = base_q;
        beat_n   = beat_q;
        slot_n   = slot_q;
        base_cur = base_q;
        beat_cur = beat_q;
        slot_cur = slot_q;
        vga_iss  = 1'b0;
        cpu_iss  = 1'b0;
        last_n   = 1'b0;
        unique case (state)
            IDLE, CPU_ACC: begin
                state_n = IDLE;
                if (vga_start) begin
                    base_cur = vga_base_addr;
                    base_n   = vga_base_addr;
                    beat_cur = '0;
                    slot_cur = '0;
                    vga_iss  = 1'b1;
                end else if (state == IDLE && cpu_pend) begin
                    cpu_iss = 1'b1;
                    state_n = CPU_ACC;
                end
            end
            VGA_BURST: begin
                if (slot_q == SLOT_MAX && cpu_pend) begin
                    cpu_iss = 1'b1;
                    slot_n  = '0;
                    state_n = VGA_CPU_SLOT;
                end else begin
                    vga_iss = 1'b1;
                end
            end
            VGA_CPU_SLOT: vga_iss = 1'b1;
            default:      state_n = IDLE;
        endcase
        if (vga_iss) begin
            if (beat_cur == LAST_BEAT) begin
                last_n  = 1'b1;
                beat_n  = '0;
                slot_n  = '0;
                state_n = IDLE;
            end else begin
                beat_n  = beat_cur + 1'b1;
                slot_n  = (slot_cur == SLOT_MAX) ?
                          slot_cur : slot_cur + 1'b1;
                state_n = VGA_BURST;
            end
        end
        iss_addr = base_cur + ADDR_WIDTH'(beat_cur);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            beat_q      <= '0;
            slot_q      <= '0;
            vga_rd_q    <= 1'b0;
            last_q      <= 1'b0;
            cpu_rd_q    <= 1'b0;
            vga_rvalid  <= 1'b0;
            vga_done    <= 1'b0;
            vga_busy    <= 1'b0;
            vga_overrun <= 1'b0;
            cpu.cpu_ack <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            beat_q      <= beat_n;
            slot_q      <= slot_n;
            vga_rd_q    <= vga_iss;
            last_q      <= last_n;
            cpu_rd_q    <= cpu_iss;
            vga_rvalid  <= vga_rd_q;
            vga_done    <= last_q;
            cpu.cpu_ack <= cpu_rd_q;
            vga_busy    <= vga_iss || (state_n == VGA_CPU_SLOT);
            vga_overrun <= vga_overrun || (vga_req && vga_busy);
            mem_en      <= vga_iss || cpu_iss;
            mem_we      <= cpu_wr;
            mem_addr    <= cpu_iss ? cpu.cpu_addr :
                           (vga_iss ? iss_addr : '0);
            mem_wdata   <= cpu_wr ? cpu.cpu_wdata : '0;
            mem_wstrb   <= cpu_wr ? cpu.cpu_wstrb : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural BRAM
// whose unwritten words read back as their own address.
module tb_vga_fb_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BL = 80;
    localparam int SP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_base_addr = '0;
    logic          vga_rvalid, vga_done, vga_busy, vga_overrun;
    logic [DW-1:0] vga_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;

    vga_fb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_bus ();

    vga_fb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_LEN(BL), .CPU_SLOT_PERIOD(SP)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_base_addr(vga_base_addr),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .vga_done(vga_done), .vga_busy(vga_busy),
        .vga_overrun(vga_overrun),
        .cpu(cpu_bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: one-cycle read latency, byte strobes.
    bit [31:0] mem [16384];
    bit        wflag [16384];
    logic [31:0] wtmp;

    function automatic logic [31:0] model_word(input logic [AW-1:0] a);
        return wflag[a] ? mem[a] : {18'h0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                wtmp = model_word(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
                mem[mem_addr]   <= wtmp;
                wflag[mem_addr] <= 1'b1;
            end
            mem_rdata <= model_word(mem_addr);
        end
    end

    int checks = 0;
    int errors = 0;

    // Burst monitor results.
    int          nbeats, first_rv, last_rv, gaps, nacks, first_ack;
    int          done_step, bad_data, busy_last;
    bit          done_on_last, ovr_start;
    logic [31:0] first_addr;
    logic [31:0] cap [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input bit we, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              output int lat, output logic [31:0] rd,
                              output logic [3:0] s1, output logic ack_after);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = d;
        cpu_bus.cpu_wstrb = s;
        lat = 0;
        rd  = '0;
        s1  = '0;
        while (lat < 50) begin
            tick();
            lat++;
            if (lat == 1) s1 = mem_wstrb;
            if (cpu_bus.cpu_ack) begin
                rd = cpu_bus.cpu_rdata;
                break;
            end
        end
        cpu_bus.cpu_req = 1'b0;
        tick();
        ack_after = cpu_bus.cpu_ack;
    endtask

    task automatic run_burst(input logic [AW-1:0] base, input bit hold_cpu,
                             input int ovr_step, input int rst_after);
        int          step_n;
        bit          rst_hit;
        logic [AW-1:0] ea;
        vga_base_addr = base;
        vga_req = 1'b1;
        if (hold_cpu) begin
            cpu_bus.cpu_req  = 1'b1;
            cpu_bus.cpu_we   = 1'b0;
            cpu_bus.cpu_addr = 14'h0010;
        end
        nbeats = 0; first_rv = 0; last_rv = 0; gaps = 0;
        nacks = 0; first_ack = 0; done_step = 0; bad_data = 0;
        busy_last = 0; done_on_last = 0; first_addr = '0;
        ovr_start = 0;
        for (int i = 0; i < 16; i++) cap[i] = '0;
        step_n = 0;
        rst_hit = 0;
        while (done_step == 0 && step_n < 300 && !rst_hit) begin
            tick();
            step_n++;
            if (step_n == 1) begin
                vga_req    = 1'b0;
                first_addr = 32'(mem_addr);
                ovr_start  = vga_overrun;
            end
            if (ovr_step > 0) begin
                if (step_n == ovr_step) vga_req = 1'b1;
                else if (step_n == ovr_step + 1) vga_req = 1'b0;
            end
            if (vga_rvalid) begin
                if (nbeats == 0) first_rv = step_n;
                else if (step_n != last_rv + 1) gaps += step_n - last_rv - 1;
                ea = base + AW'(nbeats);
                if (vga_rdata !== model_word(ea)) bad_data++;
                if (nbeats < 16) cap[nbeats] = vga_rdata;
                last_rv = step_n;
                nbeats++;
                if (rst_after >= 0 && nbeats == rst_after + 1) begin
                    rst = 1'b1;
                    rst_hit = 1;
                end
            end
            if (vga_busy) busy_last = step_n;
            if (cpu_bus.cpu_ack) begin
                nacks++;
                if (first_ack == 0) first_ack = step_n;
            end
            if (vga_done) begin
                done_step = step_n;
                done_on_last = vga_rvalid && (nbeats == BL);
            end
        end
        cpu_bus.cpu_req = 1'b0;
    endtask

    int          lat, rv_cnt;
    logic [31:0] rd;
    logic [3:0]  s1;
    logic        ack_after;

    initial begin
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;
        cpu_bus.cpu_wstrb = '0;
        repeat (3) tick();
        chk("rst_ctrl", 32'({mem_en, mem_we, vga_rvalid, vga_done,
                             vga_busy, vga_overrun, cpu_bus.cpu_ack}), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        tick();

        // CPU write, checked at the BRAM port.
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = 14'h0010;
        cpu_bus.cpu_wdata = 32'hDEADBEEF;
        cpu_bus.cpu_wstrb = 4'hF;
        tick();
        chk("wr_en_we", 32'({mem_en, mem_we}), 32'h3);
        chk("wr_addr", 32'(mem_addr), 32'h10);
        chk("wr_data", mem_wdata, 32'hDEADBEEF);
        chk("wr_strb", 32'(mem_wstrb), 32'hF);
        chk("wr_no_early_ack", 32'(cpu_bus.cpu_ack), 32'h0);
        tick();
        chk("wr_ack", 32'(cpu_bus.cpu_ack), 32'h1);
        cpu_bus.cpu_req = 1'b0;
        tick();
        chk("wr_ack_pulse", 32'(cpu_bus.cpu_ack), 32'h0);

        cpu_access(1'b0, 14'h0010, 32'h0, 4'h0, lat, rd, s1, ack_after);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_strb0", 32'(s1), 32'h0);
        chk("rd_ack_pulse", 32'(ack_after), 32'h0);

        // Byte-strobe merge.
        cpu_access(1'b1, 14'h0020, 32'h11223344, 4'hF, lat, rd, s1, ack_after);
        cpu_access(1'b1, 14'h0020, 32'hAABBCCDD, 4'h5, lat, rd, s1, ack_after);
        chk("bs_wr_lat", 32'(lat), 32'd2);
        cpu_access(1'b0, 14'h0020, 32'h0, 4'h0, lat, rd, s1, ack_after);
        chk("bs_rd_data", rd, 32'h11BB33DD);

        // Lone burst with a mid-burst overrun request.
        run_burst(14'h0100, 1'b0, 40, -1);
        chk("b1_addr0", first_addr, 32'h100);
        chk("b1_ovr_start", 32'(ovr_start), 32'h0);
        chk("b1_first_rv", 32'(first_rv), 32'd2);
        chk("b1_nbeats", 32'(nbeats), 32'd80);
        chk("b1_data", 32'(bad_data), 32'd0);
        chk("b1_cap0", cap[0], 32'h100);
        chk("b1_gaps", 32'(gaps), 32'd0);
        chk("b1_done_step", 32'(done_step), 32'd81);
        chk("b1_done_last", 32'(done_on_last), 32'h1);
        chk("b1_busy_last", 32'(busy_last), 32'd80);
        chk("b1_overrun", 32'(vga_overrun), 32'h1);
        repeat (2) tick();

        // Simultaneous start, CPU held for the whole burst.
        run_burst(14'h0100, 1'b1, 0, -1);
        chk("b2_vga_first", first_addr, 32'h100);
        chk("b2_first_rv", 32'(first_rv), 32'd2);
        chk("b2_first_ack", 32'(first_ack), 32'd10);
        chk("b2_nacks", 32'(nacks), 32'd9);
        chk("b2_gaps", 32'(gaps), 32'd9);
        chk("b2_span", 32'(last_rv - first_rv + 1), 32'd89);
        chk("b2_nbeats", 32'(nbeats), 32'd80);
        chk("b2_data", 32'(bad_data), 32'd0);
        chk("b2_done_step", 32'(done_step), 32'd90);
        repeat (4) tick();

        // Burst across the top of the address space.
        run_burst(14'h3FF8, 1'b0, 0, -1);
        chk("b3_addr0", first_addr, 32'h3FF8);
        chk("b3_cap7", cap[7], 32'h3FFF);
        chk("b3_cap8", cap[8], 32'h0);
        chk("b3_cap9", cap[9], 32'h1);
        chk("b3_nbeats", 32'(nbeats), 32'd80);
        chk("b3_data", 32'(bad_data), 32'd0);
        chk("b3_done_step", 32'(done_step), 32'd81);
        repeat (2) tick();

        // Reset during beat 5.
        run_burst(14'h3FF8, 1'b0, 0, 5);
        chk("b4_nbeats", 32'(nbeats), 32'd6);
        chk("b4_cap5", cap[5], 32'h3FFD);
        chk("b4_ovr_before", 32'(vga_overrun), 32'h1);
        tick();
        chk("b4_rst_ctrl", 32'({mem_en, mem_we, vga_rvalid, vga_done,
                                vga_busy, vga_overrun, cpu_bus.cpu_ack}), 32'h0);
        chk("b4_rst_bus", 32'(mem_addr) | mem_wdata | 32'(mem_wstrb), 32'h0);
        rst = 1'b0;
        rv_cnt = 0;
        repeat (12) begin
            tick();
            if (vga_rvalid || vga_done) rv_cnt++;
        end
        chk("b4_no_rvalid", 32'(rv_cnt), 32'd0);

        cpu_access(1'b0, 14'h0010, 32'h0, 4'h0, lat, rd, s1, ack_after);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_data", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
